// File: rtl/pit_pkg.sv
// Shared definitions for the programmable interrupt timer: control bit positions,
// read image layout and the control register struct.
package pit_pkg;

  localparam int CNT_EN_B  = 0;
  localparam int IRQ_EN_B  = 1;
  localparam int FLAG_B    = 2;
  localparam int SLAVE_B   = 3;

  localparam int PRE_LSB   = 8;
  localparam int PRE_MSB   = 11;
  localparam int PRE_W     = PRE_MSB - PRE_LSB + 1;
  localparam int PRE_CNT_W = 15;

  localparam int IMG_W     = 48;
  localparam int CTRL_LSB  = 0;
  localparam int CTRL_MSB  = 15;
  localparam int MOD_LSB   = 16;
  localparam int MOD_MSB   = 31;
  localparam int CNT_LSB   = 32;
  localparam int CNT_MSB   = 47;

  // Field order mirrors the register bit layout, MSB first.
  typedef struct packed {
    logic [3:0]       rsvd_hi;
    logic [PRE_W-1:0] pre;
    logic [3:0]       rsvd_lo;
    logic             slave;
    logic             flag;
    logic             irq_en;
    logic             cnt_en;
  } ctrl_t;

  function automatic logic [PRE_CNT_W-1:0] pre_mask(input logic [PRE_W-1:0] pre);
    return PRE_CNT_W'((32'd1 << pre) - 32'd1);
  endfunction

endpackage

// File: rtl/pit_prescale.sv
// 2^PRE clock prescaler: emits a one-cycle tick every 2^PRE enabled cycles and
// restarts from zero whenever it is cleared or disabled.
module pit_prescale
  import pit_pkg::*;
(
  input  logic             clk,
  input  logic             async_rst_b,
  input  logic             i_sync_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [PRE_W-1:0] i_pre,
  output logic             o_tick
);

  logic [PRE_CNT_W-1:0] r_pre_cnt;
  logic                 w_at_mask;

  assign w_at_mask = (r_pre_cnt == pre_mask(i_pre));
  assign o_tick    = i_enable && w_at_mask;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      r_pre_cnt <= '0;
    end else if (i_sync_reset || i_clear || !i_enable || w_at_mask) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pit_counter_core.sv
// Timer datapath: control/modulo registers, prescaler, modulo counter and
// interrupt flag / terminal-count pulse generation.
module pit_counter_core
  import pit_pkg::*;
#(
  parameter int D_WIDTH     = 16,
  parameter int COUNT_SIZE  = 16,
  parameter bit NO_PRESCALE = 1'b0
) (
  input  logic               wb_clk,
  input  logic               async_rst_b,
  input  logic               sync_reset,
  input  logic [3:0]         write_regs,
  input  logic [D_WIDTH-1:0] write_data,
  input  logic               ext_sync_i,
  output logic [IMG_W-1:0]   read_regs,
  output logic               irq_source,
  output logic               pit_o
);

  ctrl_t                 r_ctrl;
  ctrl_t                 w_ctrl_nxt;
  logic [COUNT_SIZE-1:0] r_mod;
  logic [COUNT_SIZE-1:0] w_mod_nxt;
  logic [COUNT_SIZE-1:0] r_cnt;
  logic [COUNT_SIZE-1:0] w_cnt_nxt;
  logic [COUNT_SIZE-1:0] w_mod_last;
  logic                  r_pit;

  logic [15:0] w_wdata16;
  logic [7:0]  w_lo;
  logic [7:0]  w_hi;
  logic        w_restart;
  logic        w_pre_clear;
  logic        w_pre_tick;
  logic        w_tick;
  logic        w_terminal;
  logic        w_term_eff;

  // An 8-bit bus presents the same byte to every lane; odd lanes then see it too.
  generate
    if (D_WIDTH == 8) begin : g_bus8
      assign w_wdata16 = {2{write_data[7:0]}};
    end else begin : g_bus16
      assign w_wdata16 = write_data[15:0];
    end
  endgenerate

  assign w_lo = w_wdata16[7:0];
  assign w_hi = w_wdata16[15:8];

  assign w_restart  = |write_regs[3:1];
  assign w_mod_last = r_mod - 1'b1;
  assign w_tick     = r_ctrl.cnt_en && (r_ctrl.slave ? ext_sync_i : w_pre_tick);
  assign w_terminal = w_tick && (r_cnt == w_mod_last);
  assign w_term_eff = w_terminal && !w_restart;

  generate
    if (NO_PRESCALE) begin : g_no_pre
      assign w_pre_tick = r_ctrl.cnt_en;
    end else begin : g_pre
      pit_prescale u_prescale (
        .clk          (wb_clk),
        .async_rst_b  (async_rst_b),
        .i_sync_reset (sync_reset),
        .i_clear      (w_pre_clear),
        .i_enable     (r_ctrl.cnt_en),
        .i_pre        (r_ctrl.pre),
        .o_tick       (w_pre_tick)
      );
    end
  endgenerate

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    w_mod_nxt  = r_mod;
    w_cnt_nxt  = r_cnt;

    if (write_regs[0]) begin
      w_ctrl_nxt.cnt_en = w_lo[CNT_EN_B];
      w_ctrl_nxt.irq_en = w_lo[IRQ_EN_B];
      w_ctrl_nxt.slave  = w_lo[SLAVE_B];
      if (w_lo[FLAG_B]) w_ctrl_nxt.flag = 1'b0;
    end
    if (write_regs[1]) w_ctrl_nxt.pre = w_hi[PRE_LSB-8 +: PRE_W];
    // Setting the flag is evaluated last so it beats a same-cycle clear-write.
    if (w_term_eff) w_ctrl_nxt.flag = 1'b1;
    w_ctrl_nxt.rsvd_hi = '0;
    w_ctrl_nxt.rsvd_lo = '0;

    if (write_regs[2]) w_mod_nxt[7:0]  = w_lo;
    if (write_regs[3]) w_mod_nxt[15:8] = w_hi;

    w_pre_clear = w_restart || !w_ctrl_nxt.cnt_en;
    if (w_pre_clear || w_term_eff) begin
      w_cnt_nxt = '0;
    end else if (w_tick) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      r_ctrl <= '0;
      r_mod  <= '0;
      r_cnt  <= '0;
      r_pit  <= 1'b0;
    end else if (sync_reset) begin
      r_ctrl <= '0;
      r_mod  <= '0;
      r_cnt  <= '0;
      r_pit  <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl_nxt;
      r_mod  <= w_mod_nxt;
      r_cnt  <= w_cnt_nxt;
      r_pit  <= w_term_eff;
    end
  end

  assign read_regs[CTRL_MSB:CTRL_LSB] = r_ctrl;
  assign read_regs[MOD_MSB:MOD_LSB]   = r_mod;
  assign read_regs[CNT_MSB:CNT_LSB]   = r_cnt;
  assign irq_source                   = r_ctrl.flag & r_ctrl.irq_en;
  assign pit_o                        = r_pit;

endmodule

// File: doc/pit_counter_core.md
# pit_counter_core

Timer datapath of the programmable interrupt timer: consumes the decoded register write strobes and write data from the WISHBONE bus stage and returns the 48-bit read register image plus the interrupt request. It contains:
- the control/status register and the modulo register;
- a 2^N clock prescaler;
- the modulo counter;
- interrupt flag and timer-pulse generation.

## Interface
Parameters:
- D_WIDTH, 16, bus data width; 8 or 16 only.
- COUNT_SIZE, 16, modulo/counter width; fixed at 16 for the 48-bit image.
- NO_PRESCALE, 1'b0, when 1 the prescaler is removed and every enabled cycle is a tick.

Ports:
- wb_clk  in  1  master clock.
- async_rst_b  in  1  reset, asynchronous, active-low.
- sync_reset  in  1  synchronous active-high reset; same effect as async reset, on the next edge.
- write_regs  in  4  byte-lane write strobes. [1:0] are control bytes 0/1; [3:2] are modulo bytes 0/1.
- write_data  in  D_WIDTH  bus write data.
- ext_sync_i  in  1  external tick enable, used in SLAVE mode.
- read_regs  out  48  [15:0] control/status, [31:16] modulo, [47:32] live counter.
- irq_source  out  1  FLAG & IRQ_EN.
- pit_o  out  1  one-cycle terminal-count pulse.

## Operation
- **Byte-lane mapping**
  - In 8-bit mode, any strobed lane takes write_data[7:0].
  - In 16-bit mode, lane pairs {1,0} and {3,2} take write_data[15:8] / [7:0].
- **Control register bits**
  - 0 CNT_EN.
  - 1 IRQ_EN.
  - 2 FLAG: status. Writing 1 clears it; writing 0 has no effect.
  - 3 SLAVE: tick source is ext_sync_i instead of the prescaler.
  - [11:8] PRE: prescale divide 2^PRE.
  - [15:12] and [7:4] are reserved and read 0.
- **Prescaler** (sub-module): 15-bit up-counter.
  - tick when pre_cnt == (1<<PRE)-1, then pre_cnt returns to 0.
  - PRE=0 gives a tick every cycle.
- **Counter**: counts ticks from 0.
  - Terminal when cnt == modulo-1, computed mod 2^16.
  - modulo 0 therefore gives a period of 65536 ticks; modulo 1 terminates on every tick.
  - On terminal tick: cnt←0, FLAG←1, pit_o←1 for one cycle.
- **Restart**: a write to either modulo byte, or to control byte 1, clears cnt and pre_cnt.
- **Disable**: CNT_EN=0 holds cnt and pre_cnt at 0; no ticks are generated.
- **Simultaneous events**
  - FLAG set and FLAG clear-write in the same cycle: set wins.
  - Restart write and terminal tick in the same cycle: restart wins; no flag, no pulse.

## Timing
- **Reset values**: all registers 0; read_regs = 48'h0; irq_source = 0; pit_o = 0.
- **Write latency**: write_regs is sampled at edge E; the new value is visible on read_regs after E. There is no combinational path from write_regs to read_regs.
- **Terminal tick at edge E**: pit_o and FLAG are both high after E. pit_o is low after E+1 unless another terminal tick occurs.
- **irq_source**: combinational AND of registered bits; it drops one cycle after a FLAG clear-write.
- **Pulse period**: in non-SLAVE mode with CNT_EN=1, the period is modulo × 2^PRE cycles (modulo 0 → 65536).
- **Async reset mid-count**: immediately zeroes all state. sync_reset zeroes all state at the next edge and has priority over writes and ticks.

## Structure
- **pit_pkg** holds:
  - control bit index constants (CNT_EN_B, IRQ_EN_B, FLAG_B, SLAVE_B);
  - PRE field bounds;
  - read image slice constants;
  - a typedef for the control register struct.
- **pit_prescale** sub-module
  - Inputs: clk, resets, clear, enable, pre[3:0].
  - Output: tick.
  - Tied off when NO_PRESCALE=1.

## Test plan
- **16-bit basic period**: write modulo 3, then control 16'h0003. Expect pit_o every 3 cycles, FLAG=1 and irq_source=1 after the first terminal tick.
- **Prescale**: control PRE=2, modulo 2, CNT_EN. Expect a pit_o period of 8 cycles and read_regs[47:32] stepping every 4 cycles.
- **FLAG clear collision**: write 1 to FLAG on the same edge as a terminal tick. Expect FLAG to remain 1. A clear-write one cycle later leaves FLAG=0 and irq_source=0.
- **8-bit lanes and modulo 0**: D_WIDTH=8; write lanes 2 and 3 with 8'h00, SLAVE=1, ext_sync_i pulsed. Expect the terminal tick after exactly 65536 pulses and the counter wrapping 16'hFFFF→0.
- **Restart write**: mid-count, rewrite modulo 5. Expect the counter to read 0 the next cycle and a full 5-tick period with no pulse at the old terminal.
- **Reset mid-operation**: assert async_rst_b low mid-count. Expect read_regs=0, pit_o=0 and irq_source=0 asynchronously. A sync_reset pulse gives the same result at the next edge.
